// File: rtl/zap_wb_arb_pkg.sv
// Shared definitions for the ZAP Wishbone burst arbiter.
// Contents: FSM state / grant encodings, Wishbone CTI constants, counter
// width and an end-of-burst helper used by the arbiter FSM.
package zap_wb_arb_pkg;

    localparam int unsigned CTR_W = 8;

    // FSM states; the encoding doubles as the debug grant value.
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_CODE = 2'b01;
    localparam logic [1:0] ST_DATA = 2'b10;

    localparam logic [1:0] GRANT_IDLE = 2'b00;
    localparam logic [1:0] GRANT_CODE = 2'b01;
    localparam logic [1:0] GRANT_DATA = 2'b10;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    // An acked beat closes the burst if it is the last of a burst or a classic cycle.
    function automatic logic burst_end(input logic ack, input logic [2:0] cti);
        return ack && ((cti == CTI_EOB) || (cti == CTI_CLASSIC));
    endfunction

endpackage

// File: rtl/zap_wb_arb_starve_ctr.sv
// Saturating count of consecutive data wins taken while code was pending.
// Ports:
//   i_clk, i_reset_n   clock, synchronous active-low reset
//   i_inc              data won arbitration while code was waiting
//   i_clr              code won arbitration
//   o_limit_reached    count has reached LIMIT; next contested grant goes to code
module zap_wb_arb_starve_ctr
    import zap_wb_arb_pkg::*;
#(
    parameter int unsigned LIMIT = 32'd8
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_limit_reached
);

    localparam logic [CTR_W-1:0] LIMIT_V = CTR_W'(LIMIT);

    logic [CTR_W-1:0] cnt;

    // Clear has priority; increments stop once the limit is reached.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            cnt <= '0;
        end else if (i_clr) begin
            cnt <= '0;
        end else if (i_inc && (cnt < LIMIT_V)) begin
            cnt <= cnt + CTR_W'(1);
        end
    end

    assign o_limit_reached = (cnt == LIMIT_V);

endmodule

// File: rtl/zap_wb_burst_arbiter.sv
// Two-port Wishbone arbiter sharing one external bus between the code and
// data cache refill/write-back engines. Grant is held for a whole burst,
// ended by an acked CTI end-of-burst/classic beat or by the owner dropping cyc.
// Data has priority; with ZAP_WB_ARB_STARVE_EN defined, code is forced after
// STARVE_LIMIT consecutive contested data wins.
// Ports:
//   i_clk, i_reset_n            clock, synchronous active-low reset
//   i_c_wb_*  / o_c_wb_ack      code requester Wishbone slave port
//   i_d_wb_*  / o_d_wb_ack      data requester Wishbone slave port
//   o_wb_*    / i_wb_ack        shared master port (combinational owner mux)
//   o_grant                     debug: 00 idle, 01 code, 10 data
// Build option: ZAP_WB_ARB_STARVE_EN enables the starvation guard.
module zap_wb_burst_arbiter
    import zap_wb_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 32'd8
) (
    input  logic        i_clk,
    input  logic        i_reset_n,

    input  logic        i_c_wb_cyc,
    input  logic        i_c_wb_stb,
    input  logic        i_c_wb_wen,
    input  logic [3:0]  i_c_wb_sel,
    input  logic [31:0] i_c_wb_dat,
    input  logic [31:0] i_c_wb_adr,
    input  logic [2:0]  i_c_wb_cti,
    output logic        o_c_wb_ack,

    input  logic        i_d_wb_cyc,
    input  logic        i_d_wb_stb,
    input  logic        i_d_wb_wen,
    input  logic [3:0]  i_d_wb_sel,
    input  logic [31:0] i_d_wb_dat,
    input  logic [31:0] i_d_wb_adr,
    input  logic [2:0]  i_d_wb_cti,
    output logic        o_d_wb_ack,

    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic        o_wb_wen,
    output logic [3:0]  o_wb_sel,
    output logic [31:0] o_wb_dat,
    output logic [31:0] o_wb_adr,
    output logic [2:0]  o_wb_cti,
    input  logic        i_wb_ack,

    output logic [1:0]  o_grant
);

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       starve_hit;

`ifdef ZAP_WB_ARB_STARVE_EN
    logic starve_inc;
    logic starve_clr;

    // Count only data wins that actually made code wait.
    assign starve_inc = (state == ST_IDLE) && (state_nxt == ST_DATA) && i_c_wb_cyc;
    assign starve_clr = (state == ST_IDLE) && (state_nxt == ST_CODE);

    zap_wb_arb_starve_ctr #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve_ctr (
        .i_clk           (i_clk),
        .i_reset_n       (i_reset_n),
        .i_inc           (starve_inc),
        .i_clr           (starve_clr),
        .o_limit_reached (starve_hit)
    );
`else
    logic unused_starve_limit;

    assign starve_hit          = 1'b0;
    assign unused_starve_limit = ^STARVE_LIMIT;
`endif

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Arbitration, release and owner mux; every release passes through IDLE.
    always_comb begin
        state_nxt  = state;
        o_wb_cyc   = 1'b0;
        o_wb_stb   = 1'b0;
        o_wb_wen   = 1'b0;
        o_wb_sel   = 4'h0;
        o_wb_dat   = 32'h0;
        o_wb_adr   = 32'h0;
        o_wb_cti   = CTI_CLASSIC;
        o_c_wb_ack = 1'b0;
        o_d_wb_ack = 1'b0;
        o_grant    = GRANT_IDLE;

        case (state)
            ST_IDLE: begin
                if (i_d_wb_cyc && !(i_c_wb_cyc && starve_hit)) begin
                    state_nxt = ST_DATA;
                end else if (i_c_wb_cyc) begin
                    state_nxt = ST_CODE;
                end
            end

            ST_CODE: begin
                o_grant    = GRANT_CODE;
                o_wb_cyc   = i_c_wb_cyc;
                o_wb_stb   = i_c_wb_stb;
                o_wb_wen   = i_c_wb_wen;
                o_wb_sel   = i_c_wb_sel;
                o_wb_dat   = i_c_wb_dat;
                o_wb_adr   = i_c_wb_adr;
                o_wb_cti   = i_c_wb_cti;
                o_c_wb_ack = i_wb_ack;
                if (!i_c_wb_cyc || burst_end(i_wb_ack, i_c_wb_cti)) begin
                    state_nxt = ST_IDLE;
                end
            end

            ST_DATA: begin
                o_grant    = GRANT_DATA;
                o_wb_cyc   = i_d_wb_cyc;
                o_wb_stb   = i_d_wb_stb;
                o_wb_wen   = i_d_wb_wen;
                o_wb_sel   = i_d_wb_sel;
                o_wb_dat   = i_d_wb_dat;
                o_wb_adr   = i_d_wb_adr;
                o_wb_cti   = i_d_wb_cti;
                o_d_wb_ack = i_wb_ack;
                if (!i_d_wb_cyc || burst_end(i_wb_ack, i_d_wb_cti)) begin
                    state_nxt = ST_IDLE;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_zap_wb_burst_arbiter.sv
// Self-checking bench for zap_wb_burst_arbiter: requester models push expected
// beats as they drive them, a negedge monitor captures acked beats per port,
// and each test pops and compares the two.
module tb_zap_wb_burst_arbiter;
    import zap_wb_arb_pkg::*;

    localparam int unsigned LIMIT  = 3;
    localparam int          BUDGET = 400;

    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        wen;
        logic [2:0]  cti;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  rq_cyc, rq_stb, rq_wen;
    logic [3:0]  rq_sel [2];
    logic [31:0] rq_adr [2];
    logic [31:0] rq_dat [2];
    logic [2:0]  rq_cti [2];
    logic        ack_en, ack_force;
    logic        wb_ack;

    logic        o_c_wb_ack, o_d_wb_ack;
    logic        o_wb_cyc, o_wb_stb, o_wb_wen;
    logic [3:0]  o_wb_sel;
    logic [31:0] o_wb_dat, o_wb_adr;
    logic [2:0]  o_wb_cti;
    logic [1:0]  o_grant;
    logic [1:0]  rq_ack;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Zero-wait slave; ack_force drives a stray ack regardless of the bus.
    assign wb_ack = ack_force | (ack_en & o_wb_cyc & o_wb_stb);
    assign rq_ack = {o_d_wb_ack, o_c_wb_ack};

    zap_wb_burst_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .i_clk      (clk),
        .i_reset_n  (rst_n),
        .i_c_wb_cyc (rq_cyc[0]), .i_c_wb_stb (rq_stb[0]), .i_c_wb_wen (rq_wen[0]),
        .i_c_wb_sel (rq_sel[0]), .i_c_wb_dat (rq_dat[0]), .i_c_wb_adr (rq_adr[0]),
        .i_c_wb_cti (rq_cti[0]), .o_c_wb_ack (o_c_wb_ack),
        .i_d_wb_cyc (rq_cyc[1]), .i_d_wb_stb (rq_stb[1]), .i_d_wb_wen (rq_wen[1]),
        .i_d_wb_sel (rq_sel[1]), .i_d_wb_dat (rq_dat[1]), .i_d_wb_adr (rq_adr[1]),
        .i_d_wb_cti (rq_cti[1]), .o_d_wb_ack (o_d_wb_ack),
        .o_wb_cyc   (o_wb_cyc), .o_wb_stb (o_wb_stb), .o_wb_wen (o_wb_wen),
        .o_wb_sel   (o_wb_sel), .o_wb_dat (o_wb_dat), .o_wb_adr (o_wb_adr),
        .o_wb_cti   (o_wb_cti), .i_wb_ack (wb_ack),
        .o_grant    (o_grant)
    );

    // Scoreboard and monitor state.
    beat_t exp_c_q[$], exp_d_q[$], obs_c_q[$], obs_d_q[$];
    int        cyc_n = 0;
    int        d_eob_cnt, d_before_code, d_last_ack_cyc, grant_gap;
    bit        c_seen, cg_seen, c_ack_prev, d_ack_prev;
    logic [1:0] post_c_grant, post_d_grant;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    always @(negedge clk) begin
        if (c_ack_prev) post_c_grant = o_grant;
        if (d_ack_prev) post_d_grant = o_grant;
        c_ack_prev = o_c_wb_ack;
        d_ack_prev = o_d_wb_ack;
        if (o_c_wb_ack) begin
            obs_c_q.push_back({o_wb_adr, o_wb_dat, o_wb_sel, o_wb_wen, o_wb_cti});
            if (!c_seen) begin
                c_seen        = 1'b1;
                d_before_code = d_eob_cnt;
            end
        end
        if (o_d_wb_ack) begin
            obs_d_q.push_back({o_wb_adr, o_wb_dat, o_wb_sel, o_wb_wen, o_wb_cti});
            d_last_ack_cyc = cyc_n;
            if (o_wb_cti == CTI_EOB) d_eob_cnt++;
        end
        if ((o_grant == GRANT_CODE) && !cg_seen) begin
            cg_seen   = 1'b1;
            grant_gap = cyc_n - d_last_ack_cyc;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic clear_sb();
        exp_c_q.delete(); exp_d_q.delete(); obs_c_q.delete(); obs_d_q.delete();
        d_eob_cnt = 0; d_before_code = -1; d_last_ack_cyc = 0; grant_gap = -1;
        c_seen = 1'b0; cg_seen = 1'b0; c_ack_prev = 1'b0; d_ack_prev = 1'b0;
        post_c_grant = 2'b11; post_d_grant = 2'b11;
    endtask

    task automatic idle_reqs();
        rq_cyc = 2'b00; rq_stb = 2'b00; rq_wen = 2'b00;
        for (int p = 0; p < 2; p++) begin
            rq_sel[p] = 4'h0; rq_adr[p] = 32'h0; rq_dat[p] = 32'h0; rq_cti[p] = CTI_CLASSIC;
        end
    endtask

    task automatic do_reset();
        idle_reqs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Drive one burst on a requester port, pushing each beat as it is presented.
    // Stops after stop_at acks; if that is short of the burst, the next beat stays presented.
    task automatic run_req(input bit port, input logic [31:0] base, input int beats,
                           input int stop_at, input logic wen, input logic [3:0] sel,
                           output bit timed_out);
        int   b;
        int   waited;
        logic got;
        beat_t e;
        timed_out = 1'b0;
        b = 0;
        rq_cyc[port] = 1'b1; rq_stb[port] = 1'b1; rq_wen[port] = wen; rq_sel[port] = sel;
        while ((b < stop_at) && !timed_out) begin
            rq_adr[port] = base + 32'(4 * b);
            rq_dat[port] = base ^ {16'hC0DE, 16'(b)};
            rq_cti[port] = (beats == 1) ? CTI_CLASSIC : ((b == beats - 1) ? CTI_EOB : CTI_INCR);
            e = {rq_adr[port], rq_dat[port], sel, wen, rq_cti[port]};
            if (port == 1'b0) exp_c_q.push_back(e); else exp_d_q.push_back(e);
            got = 1'b0;
            waited = 0;
            while (!got && (waited < BUDGET)) begin
                @(negedge clk);
                got = rq_ack[port];
                @(posedge clk);
                #1;
                waited++;
            end
            if (!got) timed_out = 1'b1; else b++;
        end
        if ((b >= beats) || timed_out) begin
            rq_cyc[port] = 1'b0; rq_stb[port] = 1'b0; rq_wen[port] = 1'b0;
            rq_sel[port] = 4'h0; rq_adr[port] = 32'h0; rq_dat[port] = 32'h0;
            rq_cti[port] = CTI_CLASSIC;
        end else begin
            rq_adr[port] = base + 32'(4 * b);
            rq_dat[port] = base ^ {16'hC0DE, 16'(b)};
            rq_cti[port] = CTI_INCR;
        end
    endtask

    task automatic test_reset();
        clear_sb();
        idle_reqs();
        ack_en = 1'b0; ack_force = 1'b1;
        rst_n = 1'b0;
        rq_cyc = 2'b11; rq_stb = 2'b11; rq_wen = 2'b10;
        rq_adr[0] = 32'h100; rq_adr[1] = 32'h200;
        rq_dat[0] = 32'h1111_1111; rq_dat[1] = 32'h2222_2222;
        rq_sel[0] = 4'hF; rq_sel[1] = 4'hF;
        rq_cti[0] = CTI_INCR; rq_cti[1] = CTI_INCR;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if ({o_wb_cyc, o_wb_stb, o_wb_wen, o_wb_sel, o_wb_dat, o_wb_adr, o_wb_cti,
                 o_c_wb_ack, o_d_wb_ack} !== 76'd0) begin
                n_fail++;
                $display("FAIL reset_outputs cycle %0d: got cyc=%b adr=%h acks=%b%b want all zero",
                         i, o_wb_cyc, o_wb_adr, o_c_wb_ack, o_d_wb_ack);
            end
            n_checks++;
            if (o_grant !== GRANT_IDLE) begin
                n_fail++;
                $display("FAIL reset_grant cycle %0d: got %b want 00", i, o_grant);
            end
            @(posedge clk);
            #1;
        end
        ack_force = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        n_checks++;
        if ((o_grant !== GRANT_DATA) || (o_wb_cyc !== 1'b1) || (o_wb_adr !== 32'h200)
            || (o_wb_wen !== 1'b1)) begin
            n_fail++;
            $display("FAIL reset_release_grant: got grant=%b cyc=%b adr=%h wen=%b want 10 1 00000200 1",
                     o_grant, o_wb_cyc, o_wb_adr, o_wb_wen);
        end
        @(posedge clk);
        #1;
        idle_reqs();
        @(posedge clk);
        #1;
        @(negedge clk);
        n_checks++;
        if (o_grant !== GRANT_IDLE) begin
            n_fail++;
            $display("FAIL reset_cyc_drop_release: got grant=%b want 00", o_grant);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_code_burst();
        bit    to;
        bit    done;
        beat_t e, o;
        clear_sb();
        done = 1'b0;
        ack_en = 1'b1;
        fork
            begin
                run_req(1'b0, 32'h0000_1000, 16, 16, 1'b0, 4'hF, to);
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    ack_en = ($urandom_range(0, 3) != 0);
                end
                ack_en = 1'b1;
            end
        join
        @(negedge clk);
        @(posedge clk);
        #1;
        n_checks++;
        if (to !== 1'b0) begin n_fail++; $display("FAIL code_burst_timeout: got %b want 0", to); end
        n_checks++;
        if (obs_c_q.size() !== 16) begin
            n_fail++; $display("FAIL code_burst_ack_count: got %0d want 16", obs_c_q.size());
        end
        n_checks++;
        if (obs_d_q.size() !== 0) begin
            n_fail++; $display("FAIL code_burst_data_ack: got %0d want 0", obs_d_q.size());
        end
        while ((exp_c_q.size() > 0) && (obs_c_q.size() > 0)) begin
            e = exp_c_q.pop_front();
            o = obs_c_q.pop_front();
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL code_burst_beat: got %h want %h", o, e); end
        end
        n_checks++;
        if (post_c_grant !== GRANT_IDLE) begin
            n_fail++; $display("FAIL code_burst_release: got grant=%b want 00", post_c_grant);
        end
    endtask

    task automatic test_simultaneous();
        bit    to_c, to_d;
        beat_t e, o;
        clear_sb();
        ack_en = 1'b1;
        fork
            run_req(1'b1, 32'h0000_2000, 4, 4, 1'b1, 4'hF, to_d);
            run_req(1'b0, 32'h0000_3000, 4, 4, 1'b0, 4'hF, to_c);
        join
        @(negedge clk);
        @(posedge clk);
        #1;
        n_checks++;
        if ({to_c, to_d} !== 2'b00) begin
            n_fail++; $display("FAIL simul_timeout: got %b%b want 00", to_c, to_d);
        end
        n_checks++;
        if (d_before_code !== 1) begin
            n_fail++; $display("FAIL simul_data_first: got %0d data bursts before code want 1", d_before_code);
        end
        n_checks++;
        if (grant_gap !== 2) begin
            n_fail++; $display("FAIL simul_handover_gap: got %0d cycles want 2", grant_gap);
        end
        n_checks++;
        if ((obs_c_q.size() !== 4) || (obs_d_q.size() !== 4)) begin
            n_fail++; $display("FAIL simul_ack_counts: got c=%0d d=%0d want 4 4", obs_c_q.size(), obs_d_q.size());
        end
        while ((exp_d_q.size() > 0) && (obs_d_q.size() > 0)) begin
            e = exp_d_q.pop_front();
            o = obs_d_q.pop_front();
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL simul_data_beat: got %h want %h", o, e); end
        end
        while ((exp_c_q.size() > 0) && (obs_c_q.size() > 0)) begin
            e = exp_c_q.pop_front();
            o = obs_c_q.pop_front();
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL simul_code_beat: got %h want %h", o, e); end
        end
    endtask

    task automatic test_classic();
        bit    to;
        beat_t e, o;
        clear_sb();
        ack_en = 1'b1;
        run_req(1'b1, 32'hFFFF_FFFC, 1, 1, 1'b1, 4'b0011, to);
        @(negedge clk);
        @(posedge clk);
        #1;
        n_checks++;
        if (to !== 1'b0) begin n_fail++; $display("FAIL classic_timeout: got %b want 0", to); end
        n_checks++;
        if ((obs_d_q.size() !== 1) || (obs_c_q.size() !== 0)) begin
            n_fail++; $display("FAIL classic_ack_count: got d=%0d c=%0d want 1 0", obs_d_q.size(), obs_c_q.size());
        end
        if ((exp_d_q.size() > 0) && (obs_d_q.size() > 0)) begin
            e = exp_d_q.pop_front();
            o = obs_d_q.pop_front();
            n_checks++;
            if ((o.adr !== 32'hFFFF_FFFC) || (o.sel !== 4'b0011) || (o.wen !== 1'b1)
                || (o.cti !== CTI_CLASSIC) || (o !== e)) begin
                n_fail++; $display("FAIL classic_beat: got %h want %h", o, e);
            end
        end
        n_checks++;
        if (post_d_grant !== GRANT_IDLE) begin
            n_fail++; $display("FAIL classic_release: got grant=%b want 00", post_d_grant);
        end
    endtask

    task automatic test_starvation();
        bit    to_c, to_d, to_i;
        int    exp_before;
        beat_t e, o;
`ifdef ZAP_WB_ARB_STARVE_EN
        exp_before = LIMIT;
`else
        exp_before = 20;
`endif
        do_reset();
        clear_sb();
        ack_en = 1'b1;
        to_d = 1'b0;
        fork
            run_req(1'b0, 32'h0000_4000, 2, 2, 1'b0, 4'hF, to_c);
            begin
                for (int i = 0; i < 20; i++) begin
                    run_req(1'b1, 32'h0000_5000 + 32'(i * 16), 2, 2, 1'b1, 4'hF, to_i);
                    if (to_i) to_d = 1'b1;
                end
            end
        join
        @(negedge clk);
        @(posedge clk);
        #1;
        n_checks++;
        if ({to_c, to_d} !== 2'b00) begin
            n_fail++; $display("FAIL starve_timeout: got %b%b want 00", to_c, to_d);
        end
        n_checks++;
        if (d_before_code !== exp_before) begin
            n_fail++; $display("FAIL starve_data_bursts_before_code: got %0d want %0d", d_before_code, exp_before);
        end
        n_checks++;
        if ((obs_c_q.size() !== 2) || (obs_d_q.size() !== 40)) begin
            n_fail++; $display("FAIL starve_ack_counts: got c=%0d d=%0d want 2 40", obs_c_q.size(), obs_d_q.size());
        end
        while ((exp_c_q.size() > 0) && (obs_c_q.size() > 0)) begin
            e = exp_c_q.pop_front();
            o = obs_c_q.pop_front();
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL starve_code_beat: got %h want %h", o, e); end
        end
        while ((exp_d_q.size() > 0) && (obs_d_q.size() > 0)) begin
            e = exp_d_q.pop_front();
            o = obs_d_q.pop_front();
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL starve_data_beat: got %h want %h", o, e); end
        end
    endtask

    task automatic test_reset_mid_burst();
        bit    to;
        int    snap;
        beat_t e, o;
        clear_sb();
        ack_en = 1'b1;
        run_req(1'b0, 32'h0000_6000, 8, 5, 1'b0, 4'hF, to);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        ack_force = 1'b1;
        snap = obs_c_q.size();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if ({o_wb_cyc, o_wb_stb, o_wb_wen, o_wb_sel, o_wb_dat, o_wb_adr, o_wb_cti,
                 o_c_wb_ack, o_d_wb_ack, o_grant} !== 78'd0) begin
                n_fail++;
                $display("FAIL midburst_reset_outputs cycle %0d: got cyc=%b adr=%h acks=%b%b grant=%b want all zero",
                         i, o_wb_cyc, o_wb_adr, o_c_wb_ack, o_d_wb_ack, o_grant);
            end
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (obs_c_q.size() !== snap) begin
            n_fail++; $display("FAIL midburst_ack_after_reset: got %0d acks want %0d", obs_c_q.size(), snap);
        end
        n_checks++;
        if ((to !== 1'b0) || (snap < 5)) begin
            n_fail++; $display("FAIL midburst_pre_reset_acks: got %0d timeout=%b want >=5 0", snap, to);
        end
        while ((exp_c_q.size() > 0) && (obs_c_q.size() > 0)) begin
            e = exp_c_q.pop_front();
            o = obs_c_q.pop_front();
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL midburst_beat: got %h want %h", o, e); end
        end
        idle_reqs();
        ack_force = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        n_checks++;
        if ((o_grant !== GRANT_IDLE) || (o_c_wb_ack !== 1'b0)) begin
            n_fail++; $display("FAIL midburst_abandoned: got grant=%b ack=%b want 00 0", o_grant, o_c_wb_ack);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        ack_en = 1'b0;
        ack_force = 1'b0;
        idle_reqs();
        clear_sb();
        test_reset();
        test_code_burst();
        test_simultaneous();
        test_classic();
        test_starvation();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
